load_store_unit: RTL and testbench

Multi-cycle load/store unit downstream of the ALU: it takes the ALU result as the effective address, performs the byte/half/word access on a ready-handshaked data-memory bus, and returns sign/zero-extended load data to the writeback mux. The unit holds the core with a combinational `stall` for the duration of each memory access. It replaces the ideal single-cycle data memory when the data memory is backed by a shared or wait-stated bus.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 58 +++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states and size decode.
package lsu_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_t;

   // Reserved encodings (011, 110, 111) fall through to a full word access.
   function automatic lsu_size_t decode_size(input logic [2:0] f3);
      lsu_size_t sz;
      case (f3)
         LSU_B, LSU_BU: sz = SZ_B;
         LSU_H, LSU_HU: sz = SZ_H;
         default:       sz = SZ_W;
      endcase
      return sz;
   endfunction

   function automatic logic is_unsigned(input logic [2:0] f3);
      return (f3 == LSU_BU) || (f3 == LSU_HU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes and replicated store data from the live request,
// lane selection and sign/zero extension of the returned bus word from the latched request.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lo,
   input  logic [31:0] wdata,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lo,
   input  logic        ld_unsigned,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      wstrb     = 4'b1111;
      wdata_rep = wdata;
      case (st_size)
         SZ_B: begin
            wstrb     = 4'b0001 << st_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         SZ_H: begin
            wstrb     = 4'b0011 << {st_lo[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         default: begin
            wstrb     = 4'b1111;
            wdata_rep = wdata;
         end
      endcase
   end

   // Half accesses look only at bit 1, which is how the forced alignment falls out for loads.
   always_comb begin
      byte_lane = rdata[7:0];
      case (ld_lo)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = ld_lo[1] ? rdata[31:16] : rdata[15:0];
      rdata_ext = rdata;
      case (ld_size)
         SZ_B:    rdata_ext = {{24{~ld_unsigned & byte_lane[7]}}, byte_lane};
         SZ_H:    rdata_ext = {{16{~ld_unsigned & half_lane[15]}}, half_lane};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit on a ready-handshaked data bus; stalls the core during each access.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into a bus-less fault.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemRead,
   input  logic            MemWrite,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] ALUResult,
   input  logic [XLEN-1:0] WriteData,
   output logic [XLEN-1:0] ReadData,
   output logic            stall,
   output logic            lsu_fault,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata
);

   lsu_state_t  state;
   lsu_state_t  next_state;
   logic        acc;
   logic        misaligned;
   logic [1:0]  st_size;
   logic [1:0]  ld_size;
   logic [1:0]  ld_lo;
   logic        ld_unsigned;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   assign acc     = MemRead | MemWrite;
   assign st_size = decode_size(funct3);

`ifdef LSU_MISALIGN_TRAP_EN
   logic fault_q;

   assign misaligned = ((st_size == SZ_H) && ALUResult[0]) ||
                       ((st_size == SZ_W) && (ALUResult[1:0] != 2'b00));
   assign lsu_fault  = fault_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fault_q <= 1'b0;
      else if (state == IDLE && acc)
         fault_q <= misaligned;
   end
`else
   assign misaligned = 1'b0;
   assign lsu_fault  = 1'b0;
`endif

   lsu_align u_align (
      .st_size     (st_size),
      .st_lo       (ALUResult[1:0]),
      .wdata       (WriteData),
      .ld_size     (ld_size),
      .ld_lo       (ld_lo),
      .ld_unsigned (ld_unsigned),
      .rdata       (mem_rdata),
      .wstrb       (st_wstrb),
      .wdata_rep   (st_wdata),
      .rdata_ext   (ld_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // DONE is the single retire cycle; the core sees stall drop exactly once per access.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (acc) next_state = misaligned ? DONE : BUSY;
         BUSY:    if (mem_ready) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      stall = acc && (state != DONE);
   end

   // Request fields are latched once on entry to BUSY and held stable until the bus answers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= 4'b0000;
         ld_size     <= SZ_W;
         ld_lo       <= 2'b00;
         ld_unsigned <= 1'b0;
         ReadData    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (acc && misaligned) begin
                  ReadData <= '0;
               end else if (acc) begin
                  mem_req     <= 1'b1;
                  mem_we      <= MemWrite;
                  mem_addr    <= {ALUResult[XLEN-1:2], 2'b00};
                  mem_wdata   <= st_wdata;
                  mem_wstrb   <= MemWrite ? st_wstrb : 4'b0000;
                  ld_size     <= st_size;
                  ld_lo       <= ALUResult[1:0];
                  ld_unsigned <= is_unsigned(funct3);
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  mem_req  <= 1'b0;
                  ReadData <= ld_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level model.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        stall;
   logic        lsu_fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad = 0;

   logic        chk_en = 1'b0;
   logic        exp_stall = 1'b0;
   logic        exp_req = 1'b0;
   logic        exp_done = 1'b0;
   logic        exp_fault = 1'b0;
   logic        exp_we = 1'b0;
   logic [31:0] exp_addr = '0;
   logic [3:0]  exp_strb = '0;
   logic [31:0] exp_wdata = '0;
   logic [31:0] model_rd = '0;

   int          stall_cnt = 0;
   int          req_cnt = 0;
   logic [31:0] seen_addr = '0;
   logic [3:0]  seen_strb = '0;
   logic [31:0] seen_wdata = '0;

   load_store_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .funct3    (funct3),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .stall     (stall),
      .lsu_fault (lsu_fault),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction model: sizes in bytes, lane offsets by plain arithmetic.
   function automatic int sizeOf(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic int laneOf(input logic [2:0] f3, input logic [31:0] a);
      int o;
      o = int'(a[1:0]);
      return o - (o % sizeOf(f3));
   endfunction

   function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] a);
      int n;
      n = sizeOf(f3);
      return 4'(((1 << n) - 1) << laneOf(f3, a));
   endfunction

   function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int n;
      n = sizeOf(f3);
      r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
      logic [31:0] v;
      logic [31:0] mask;
      int n;
      n = sizeOf(f3);
      v = rd >> (8 * laneOf(f3, a));
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      v = v & mask;
      if (f3 < 3'd4 && n < 4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One access (or one non-memory cycle) laid out on the cycle timeline the model predicts.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int lat, input logic [31:0] rdat);
      logic acc;
      logic trap;
      int   ncyc;
      acc  = rd | wr;
      trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = acc && ((int'(a[1:0]) % sizeOf(f3)) != 0);
`endif
      ncyc = !acc ? 1 : (trap ? 2 : lat + 3);
      stall_cnt = 0;
      req_cnt = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         MemRead   = rd;
         MemWrite  = wr;
         funct3    = f3;
         ALUResult = a;
         WriteData = wd;
         mem_rdata = $urandom;
         mem_ready = 1'($urandom_range(0, 1));
         exp_done  = 1'b0;
         exp_req   = 1'b0;
         exp_stall = 1'b0;
         exp_fault = 1'b0;
         exp_addr  = a & 32'hFFFF_FFFC;
         exp_we    = wr;
         exp_strb  = wr ? modelStrb(f3, a) : 4'b0000;
         exp_wdata = modelWdata(f3, wd);
         if (acc) begin
            if (c == ncyc - 1) begin
               exp_done  = 1'b1;
               exp_fault = trap;
               model_rd  = trap ? 32'h0 : modelLoad(f3, a, rdat);
            end else begin
               exp_stall = 1'b1;
               if (c >= 1) begin
                  exp_req   = 1'b1;
                  mem_ready = (c == ncyc - 2);
                  if (mem_ready) mem_rdata = rdat;
               end
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (mem_req === 1'b1) begin
         req_cnt++;
         seen_addr  = mem_addr;
         seen_strb  = mem_wstrb;
         seen_wdata = mem_wdata;
      end
      if (stall === 1'b1) stall_cnt++;
      if (chk_en) begin
         checkOutput("stall", stall, exp_stall);
         checkOutput("mem_req", mem_req, exp_req);
         checkOutput("read_data", ReadData, model_rd);
         if (exp_req) begin
            checkOutput("mem_addr", mem_addr, exp_addr);
            checkOutput("mem_we", mem_we, exp_we);
            checkOutput("mem_wstrb", mem_wstrb, exp_strb);
            if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
         end
         if (exp_done) checkOutput("lsu_fault", lsu_fault, exp_fault);
      end
   end

   initial begin
      int kind;
      reset = 1'b1;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      funct3 = 3'b000;
      ALUResult = '0;
      WriteData = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;

      @(negedge clk);
      checkOutput("rst_stall", stall, 1'b0);
      checkOutput("rst_req", mem_req, 1'b0);
      checkOutput("rst_we", mem_we, 1'b0);
      checkOutput("rst_addr", mem_addr, 32'h0);
      checkOutput("rst_wdata", mem_wdata, 32'h0);
      checkOutput("rst_wstrb", mem_wstrb, 4'b0000);
      checkOutput("rst_rdata", ReadData, 32'h0);
      checkOutput("rst_fault", lsu_fault, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;

      checkOutput("pin_strb_sh", modelStrb(3'b001, 32'h102), 4'b1100);
      checkOutput("pin_strb_sb", modelStrb(3'b000, 32'h101), 4'b0010);
      checkOutput("pin_wdata_sb", modelWdata(3'b000, 32'h1234ABCD), 32'hCDCDCDCD);
      checkOutput("pin_load_lh", modelLoad(3'b001, 32'h2, 32'h8001_0000), 32'hFFFF8001);
      checkOutput("pin_load_lhu", modelLoad(3'b101, 32'h2, 32'h8001_0000), 32'h00008001);

      chk_en = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 32'h0);

      applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
      checkOutput("lw_data", ReadData, 32'hDEADBEEF);
      checkOutput("lw_stall_cycles", stall_cnt, 2);

      applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80000000);
      checkOutput("lb_data", ReadData, 32'hFFFFFF80);
      applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80000000);
      checkOutput("lbu_data", ReadData, 32'h00000080);

      applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0);
      checkOutput("sh_addr", seen_addr, 32'h100);
      checkOutput("sh_strb", seen_strb, 4'b1100);
      checkOutput("sh_wdata", seen_wdata, 32'hABCDABCD);

      applyStimulus(1'b1, 1'b0, 3'b010, 32'h240, 32'h0, 3, 32'h0BADF00D);
      checkOutput("lw_wait_stall_cycles", stall_cnt, 5);
      checkOutput("lw_wait_data", ReadData, 32'h0BADF00D);

      applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
      checkOutput("mis_no_req", req_cnt, 0);
      checkOutput("mis_fault", lsu_fault, 1'b1);
      checkOutput("mis_data", ReadData, 32'h0);
`else
      checkOutput("mis_addr", seen_addr, 32'h100);
      checkOutput("mis_data", ReadData, 32'h11223344);
`endif

      // Reset in the middle of a bus wait: request drops, no retire cycle follows.
      chk_en = 1'b0;
      @(posedge clk);
      #1;
      MemRead = 1'b1;
      MemWrite = 1'b0;
      funct3 = 3'b010;
      ALUResult = 32'h200;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rst_mid_pre_req", mem_req, 1'b1);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checkOutput("rst_mid_req_drop", mem_req, 1'b0);
      checkOutput("rst_mid_stall", stall, 1'b1);
      checkOutput("rst_mid_rdata", ReadData, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("rst_rel_no_done", stall, 1'b1);
      checkOutput("rst_rel_req", mem_req, 1'b0);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("rst_busy_req", mem_req, 1'b1);
      checkOutput("rst_busy_addr", mem_addr, 32'h200);
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("rst_after_stall", stall, 1'b0);
      checkOutput("rst_after_data", ReadData, 32'hCAFEF00D);
      model_rd = 32'hCAFEF00D;
      chk_en = 1'b1;

      applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 32'h13579BDF);
      checkOutput("post_rst_lw", ReadData, 32'h13579BDF);

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 4);
         applyStimulus(kind < 2, kind == 2 || kind == 3, 3'($urandom_range(0, 7)),
                       $urandom, $urandom, $urandom_range(0, 3), $urandom);
      end

      @(posedge clk);
      #1 chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
